// File: rtl/posit_mult_arbiter_es3.sv
// Round-robin front end that shares one pipelined ES3 posit multiplier among NREQ requesters.
// A tag pipeline follows each issued op so the product returns to its owner; credits cap outstanding ops.
module posit_mult_arbiter_es3 #(
    parameter int NREQ    = 4,
    parameter int IN_W    = 38,
    parameter int OUT_W   = 2 * IN_W,
    parameter int LAT     = 4,
    parameter int MAX_OUT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*IN_W-1:0] req_in1,
    input  logic [NREQ*IN_W-1:0] req_in2,
    output logic [IN_W-1:0]      mult_in1,
    output logic [IN_W-1:0]      mult_in2,
    output logic                 mult_start,
    input  logic [OUT_W-1:0]     mult_result,
    input  logic                 mult_done,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [OUT_W-1:0]     rsp_result,
    output logic                 busy,
    output logic                 err_sync
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(MAX_OUT + 1);
    localparam int HW  = $clog2(LAT + 1);

    logic [IDW-1:0]   r_ptr;
    logic [CW-1:0]    r_cnt [NREQ];
    logic [LAT-1:0]   r_tag_v;
    logic [IDW-1:0]   r_tag_id [LAT];
    logic [NREQ-1:0]  r_rsp_valid;
    logic [NREQ-1:0]  r_dec;
    logic [OUT_W-1:0] r_rsp_result;
    logic [HW-1:0]    r_hold;
    logic             r_err;

    logic [NREQ-1:0]  w_elig;
    logic             w_grant;
    logic [IDW-1:0]   w_win;
    logic             w_tail_v;
    logic [IDW-1:0]   w_tail_id;
    logic [NREQ-1:0]  w_tail_oh;
    logic             w_cnt_busy;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_elig[i] = req_valid[i] && (r_cnt[i] < CW'(MAX_OUT));
        end
    end

    // Search eligible requesters starting at the pointer, wrapping modulo NREQ.
    always_comb begin
        logic [IDW:0] v_idx;
        w_grant = 1'b0;
        w_win   = '0;
        v_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = {1'b0, r_ptr} + (IDW+1)'(k);
            if (v_idx >= (IDW+1)'(NREQ)) begin
                v_idx = v_idx - (IDW+1)'(NREQ);
            end
            if (!w_grant && w_elig[v_idx[IDW-1:0]]) begin
                w_grant = 1'b1;
                w_win   = v_idx[IDW-1:0];
            end
        end
        w_grant = w_grant & rst_n;
    end

    always_comb begin
        req_ready  = '0;
        mult_in1   = '0;
        mult_in2   = '0;
        mult_start = w_grant;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant && (w_win == IDW'(i))) begin
                req_ready[i] = 1'b1;
                mult_in1     = req_in1[i*IN_W +: IN_W];
                mult_in2     = req_in2[i*IN_W +: IN_W];
            end
        end
    end

    assign w_tail_v  = r_tag_v[LAT-1];
    assign w_tail_id = r_tag_id[LAT-1];

    always_comb begin
        w_cnt_busy = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            w_tail_oh[i] = (w_tail_id == IDW'(i));
            if (r_cnt[i] != '0) begin
                w_cnt_busy = 1'b1;
            end
        end
    end

    // Tag stage 0 is loaded in the issue cycle; the tail lines up with mult_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_tag_v <= '0;
            for (int s = 0; s < LAT; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            if (w_grant) begin
                r_ptr <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
            end
            r_tag_v[0]  <= w_grant;
            r_tag_id[0] <= w_win;
            for (int s = 1; s < LAT; s++) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end
        end
    end

    // r_dec retires a credit even when the tail finds no mult_done, so credits never leak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
            r_dec        <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_rsp_valid <= (w_tail_v && mult_done) ? w_tail_oh : '0;
            r_dec       <= w_tail_v ? w_tail_oh : '0;
            if (w_tail_v && mult_done) begin
                r_rsp_result <= mult_result;
            end
            for (int i = 0; i < NREQ; i++) begin
                case ({req_ready[i], r_dec[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + 1'b1;
                    2'b01:   r_cnt[i] <= r_cnt[i] - 1'b1;
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

    // The multiplier is not reset, so its leftover done pulses are masked for LAT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= HW'(LAT);
            r_err  <= 1'b0;
        end else begin
            if (r_hold != '0) begin
                r_hold <= r_hold - 1'b1;
            end
            if ((r_hold == '0) && (mult_done != w_tail_v)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign err_sync   = r_err;
    assign busy       = (|r_tag_v) | w_cnt_busy;

endmodule

// File: tb/tb_posit_mult_arbiter_es3.sv
// Randomized scoreboard bench for posit_mult_arbiter_es3 with a delay-line multiplier stand-in.
module tb_posit_mult_arbiter_es3;

    localparam int NREQ    = 4;
    localparam int IN_W    = 38;
    localparam int OUT_W   = 2 * IN_W;
    localparam int LAT     = 4;
    localparam int MAX_OUT = 2;
    localparam int WW      = NREQ * IN_W;
    // operand pattern standing in for posit 1.0
    localparam logic [IN_W-1:0] ONE_OP = 38'h10_0000_0000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NREQ-1:0]  req_valid, req_ready, rsp_valid;
    logic [WW-1:0]    req_in1, req_in2;
    logic [IN_W-1:0]  mult_in1, mult_in2;
    logic             mult_start, mult_done, busy, err_sync;
    logic [OUT_W-1:0] mult_result, rsp_result;
    logic             inj_done = 1'b0;
    logic [LAT-1:0]   mp_v = '0;
    logic [OUT_W-1:0] mp_r [LAT];

    typedef struct { int id; int acc; logic [OUT_W-1:0] res; } exp_t;
    typedef struct { int id; int acc; } fly_t;
    typedef struct { int id; int cyc; } gnt_t;

    exp_t sbq[$];
    fly_t fly[$];
    gnt_t glog[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   m_ptr, m_hold;
    int   m_cnt [NREQ];
    bit   m_err;
    logic [OUT_W-1:0] last_res;

    posit_mult_arbiter_es3 #(
        .NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .LAT(LAT), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2),
        .mult_in1(mult_in1), .mult_in2(mult_in2), .mult_start(mult_start),
        .mult_result(mult_result), .mult_done(mult_done),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .busy(busy), .err_sync(err_sync)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stand-in: fixed LAT-cycle delay line, never reset; product is {in1,in2}.
    always @(posedge clk) begin
        mp_v    <= {mp_v[LAT-2:0], mult_start};
        mp_r[0] <= {mult_in1, mult_in2};
        for (int k = 1; k < LAT; k++) mp_r[k] <= mp_r[k-1];
    end
    assign mult_done   = mp_v[LAT-1] | inj_done;
    assign mult_result = mp_r[LAT-1];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit bit_at(input logic [NREQ-1:0] v, input int i);
        logic [NREQ-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [IN_W-1:0] get_slice(input logic [WW-1:0] v, input int i);
        logic [WW-1:0] t;
        t = v >> (i * IN_W);
        return t[IN_W-1:0];
    endfunction

    function automatic logic [WW-1:0] put_slice(input logic [WW-1:0] v, input int i,
                                                input logic [IN_W-1:0] op);
        logic [WW-1:0] m, o;
        m = {{(WW-IN_W){1'b0}}, {IN_W{1'b1}}} << (i * IN_W);
        o = {{(WW-IN_W){1'b0}}, op} << (i * IN_W);
        return (v & ~m) | o;
    endfunction

    function automatic logic [IN_W-1:0] rnd_op();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[IN_W-1:0];
    endfunction

    task automatic set_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_in1 = put_slice(req_in1, i, rnd_op());
            req_in2 = put_slice(req_in2, i, rnd_op());
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) step();
    endtask

    // Reference model: rotating-priority search, credit ledger, in-flight list and error rule.
    always @(negedge clk) begin
        int win;
        bit tail;
        bit e_busy;
        logic [NREQ-1:0] e_rdy;
        logic [IN_W-1:0] e1, e2;
        win = -1; tail = 0; e_busy = 0; e_rdy = '0; e1 = '0; e2 = '0;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_mult_start", mult_start, 0);
            chk("rst_mult_in1", mult_in1, 0);
            chk("rst_mult_in2", mult_in2, 0);
            chk("rst_busy", busy, 0);
            chk("rst_err_sync", err_sync, 0);
            m_ptr = 0; m_hold = LAT; m_err = 0;
            fly.delete();
            for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (win < 0 && bit_at(req_valid, idx) && m_cnt[idx] < MAX_OUT) win = idx;
            end
            if (win >= 0) begin
                e_rdy = NREQ'(1) << win;
                e1 = get_slice(req_in1, win);
                e2 = get_slice(req_in2, win);
            end
            for (int i = 0; i < NREQ; i++) if (m_cnt[i] != 0) e_busy = 1;
            chk("req_ready", req_ready, e_rdy);
            chk("mult_start", mult_start, win >= 0);
            chk("mult_in1", mult_in1, e1);
            chk("mult_in2", mult_in2, e2);
            chk("busy", busy, e_busy);
            chk("err_sync", err_sync, m_err);
            for (int i = 0; i < NREQ; i++)
                if (bit_at(req_ready, i)) glog.push_back('{id: i, cyc: cyc});
            foreach (fly[j]) if (fly[j].acc == cyc - LAT) tail = 1;
            if (m_hold == 0 && (mult_done != tail)) m_err = 1;
            if (m_hold > 0) m_hold--;
            if (win >= 0) begin
                m_cnt[win]++;
                fly.push_back('{id: win, acc: cyc});
                sbq.push_back('{id: win, acc: cyc, res: {e1, e2}});
                m_ptr = (win + 1) % NREQ;
            end
            while (fly.size() > 0 && fly[0].acc + LAT + 1 <= cyc) begin
                m_cnt[fly[0].id]--;
                void'(fly.pop_front());
            end
        end
    end

    // Monitor: pops the scoreboard whenever a response strobe appears.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sbq.delete();
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_result", rsp_result, 0);
            last_res = '0;
        end else begin
            if (sbq.size() > 0 && sbq[0].acc + LAT + 1 < cyc) begin
                checks++;
                failures++;
                $display("FAIL rsp_missing cyc=%0d actual=none required=id%0d", cyc, sbq[0].id);
                void'(sbq.pop_front());
            end
            if (rsp_valid != '0) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected cyc=%0d actual=%0h required=0", cyc, rsp_valid);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_onehot", rsp_valid, NREQ'(1) << e.id);
                    chk("rsp_result", rsp_result, e.res);
                    chk("rsp_cycle", cyc, e.acc + LAT + 1);
                end
                last_res = rsp_result;
            end else begin
                chk("rsp_result_hold", rsp_result, last_res);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = '1;
        req_in1 = '0;
        req_in2 = '0;
        set_ops();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(LAT + 2);

        // all requesters for 8 cycles starting from pointer 0
        glog.delete();
        req_valid = '1;
        repeat (8) begin set_ops(); step(); end
        idle(LAT + 4);
        chk("rr_count", glog.size(), 8);
        for (int k = 0; k < 8 && k < glog.size(); k++) begin
            chk("rr_order", glog[k].id, k % NREQ);
            chk("rr_back_to_back", glog[k].cyc - glog[0].cyc, k);
        end

        // single op on requester 2
        glog.delete();
        req_in1 = put_slice(req_in1, 2, ONE_OP);
        req_in2 = put_slice(req_in2, 2, ONE_OP);
        req_valid = 4'b0100;
        step();
        idle(LAT + 4);
        chk("single_count", glog.size(), 1);
        if (glog.size() > 0) chk("single_id", glog[0].id, 2);
        chk("single_busy_low", busy, 0);

        // pointer now 3: low pair wraps to 0 then 1, then pointer sits at 2
        glog.delete();
        set_ops();
        req_valid = 4'b0011;
        step();
        step();
        req_valid = 4'b1111;
        step();
        idle(LAT + 4);
        chk("wrap_count", glog.size(), 3);
        for (int k = 0; k < 3 && k < glog.size(); k++) chk("wrap_order", glog[k].id, k);

        // credit stall on requester 1
        glog.delete();
        req_valid = 4'b0010;
        repeat (10) begin set_ops(); step(); end
        idle(LAT + 4);
        chk("stall_count", glog.size(), 4);
        if (glog.size() == 4) begin
            chk("stall_gap1", glog[1].cyc - glog[0].cyc, 1);
            chk("stall_gap2", glog[2].cyc - glog[0].cyc, 6);
            chk("stall_gap3", glog[3].cyc - glog[0].cyc, 7);
        end

        // randomized traffic
        repeat (400) begin
            req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            set_ops();
            step();
        end
        idle(LAT + 4);

        // reset with three ops in flight
        set_ops();
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        rst_n = 1'b0;
        req_valid = '1;
        #1;
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_mult_start", mult_start, 0);
        chk("midrst_mult_in1", mult_in1, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_busy", busy, 0);
        step();
        rst_n = 1'b1;
        idle(LAT + 2);
        chk("midrst_no_err", err_sync, 0);
        glog.delete();
        set_ops();
        req_valid = 4'b0001;
        step();
        idle(LAT + 4);
        chk("post_rst_count", glog.size(), 1);

        // stray done with an empty tail raises the sticky error
        inj_done = 1'b1;
        step();
        inj_done = 1'b0;
        idle(6);
        chk("err_sticky", err_sync, 1);
        rst_n = 1'b0;
        #1;
        chk("err_cleared", err_sync, 0);
        step();
        rst_n = 1'b1;
        idle(LAT + 2);
        chk("sb_empty", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/posit_mult_arbiter_es3.md
Name: posit_mult_arbiter_es3

Overview:
- Shares one fully pipelined ES3 posit multiplier between NREQ requesters.
- The multiplier takes serialized ES3 operands and produces a serialized product after a fixed latency.
- Grants issue slots round-robin and tracks requester IDs through a tag pipeline matched to the multiplier latency.
- Routes each product back to its owner, bounds outstanding ops per requester with credit counters, and flags any done/tag misalignment.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IN_W, 38, serialized ES3 operand width.
- OUT_W, POSIT_SERIALIZED_WIDTH_PRODUCT_ES3, serialized product width.
- LAT, 4, multiplier latency in cycles, from start sampled to done high.
- MAX_OUT, 2, maximum outstanding ops per requester (1..7).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_in1  in  NREQ*IN_W  operand A; requester i occupies slice [i*IN_W +: IN_W].
- req_in2  in  NREQ*IN_W  operand B; same packing as req_in1.
- mult_in1  out  IN_W  to multiplier in1.
- mult_in2  out  IN_W  to multiplier in2.
- mult_start  out  1  to multiplier start.
- mult_result  in  OUT_W  from multiplier result.
- mult_done  in  1  from multiplier done.
- rsp_valid  out  NREQ  one-hot response strobe, registered.
- rsp_result  out  OUT_W  product, registered; shared by all requesters, qualified by rsp_valid.
- busy  out  1  any op in flight or any credit counter nonzero.
- err_sync  out  1  sticky: mult_done disagreed with tag pipeline.

Behaviour:
- Reset:
  - All of the following clear to 0: rsp_valid, rsp_result, err_sync, the tag pipeline, the credit counters, the RR pointer and busy.
  - The holdoff counter loads LAT.
  - req_ready, mult_start, mult_in1 and mult_in2 are combinational; they are 0 while in reset.
- Eligibility: requester i is eligible when req_valid[i]=1 and cnt[i] < MAX_OUT.
- Arbitration:
  - Combinational round-robin over eligible requesters, starting at ptr, ascending, wrapping NREQ-1 -> 0.
  - At most one grant per cycle.
  - req_ready[i]=1 only for the winner; req_ready may depend on req_valid.
- Issue:
  - In a grant cycle, mult_start=1 and mult_in1/mult_in2 = the winner's slices, same cycle (the multiplier registers them).
  - With no grant, mult_start=0 and mult_in1/mult_in2 = 0.
- Pointer: on a grant to i, ptr <= (i+1) mod NREQ. With no grant, ptr holds.
- Tag pipeline:
  - LAT-stage shift register of {v, id[clog2(NREQ)-1:0]}; advances every cycle.
  - Stage 0 loads {grant, winner id}.
  - The tail stage aligns with mult_done: accept in cycle t -> mult_done high in cycle t+LAT.
- Response:
  - When tail.v=1 and mult_done=1: next edge rsp_valid <= onehot(tail.id) and rsp_result <= mult_result.
  - Otherwise rsp_valid <= 0 and rsp_result holds.
  - End-to-end latency: accept in cycle t -> rsp_valid in cycle t+LAT+1.
  - No backpressure on responses; requesters must consume them.
- Credits:
  - cnt[i] increments on accept by i and decrements when rsp_valid[i] is registered.
  - Simultaneous increment and decrement leaves cnt unchanged.
  - cnt never exceeds MAX_OUT and never underflows.
- Error check:
  - Active only when holdoff=0. holdoff decrements by 1 per cycle after reset until it reaches 0.
  - If mult_done != tail.v, err_sync <= 1. It is sticky until reset.
  - A tail.v with no mult_done emits no response, but still decrements cnt so credits do not leak.
- Reset mid-operation:
  - In-flight ops are discarded; no rsp_valid is issued for them.
  - Stale mult_done pulses from the unreset multiplier during the LAT-cycle holdoff are ignored and raise no error.
- busy = (any tag stage v) | (any cnt != 0).
- Throughput: one issue per cycle sustained while any requester is eligible.

Test Plan:
- Single op: after reset+holdoff, req_valid[2]=1, in1=in2=posit 1.0 in cycle 10; multiplier model returns product in cycle 14 -> req_ready[2]=1 in cycle 10, rsp_valid=4'b0100 in cycle 15, cnt[2] 0->1->0, busy low from cycle 16.
- Round-robin fairness: all four req_valid held high for 8 cycles, MAX_OUT=7 -> grant order 0,1,2,3,0,1,2,3; each rsp_valid in the same order, 5 cycles after its grant.
- Credit stall:
  - MAX_OUT=2, only req 1 valid continuously -> grants in cycles t and t+1.
  - req_ready[1]=0 for cycles t+2..t+5; next grant in cycle t+6, when the first response decrements cnt.
- Wrap and skip: ptr=3, req_valid=4'b0011 -> grant 0 then 1, ptr becomes 2; an ineligible req 3 is skipped without a bubble.
- Misalignment: force mult_done high in a cycle with tail.v=0 (post-holdoff) -> err_sync=1 next cycle and stays 1 until rst_n low.
- Reset mid-flight:
  - Assert rst_n low 2 cycles after 3 issues -> all outputs 0 immediately.
  - After release, the model's stale mult_done pulses within LAT cycles produce no rsp_valid and no err_sync.
  - A new op then completes normally.
